imem_loader: RTL and testbench

Byte-stream program loader that writes the instruction memory from outside, so the CPU no longer relies on bench-preloaded IMEM contents.
- Accepts a framed byte stream on a valid/ready handshake and assembles little-endian 32-bit words.
- Drives the IMEM write port with those words.
- Holds the processor in reset until a complete, valid image is in memory.
- Sits between the host link (bench or UART receiver) and the PROCESSOR/IMEM pair.

---
 rtl/imem_loader.sv | 212 +++++++++++++++++++++
 tb/tb_imem_loader.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// imem_loader: framed byte-stream loader that writes IMEM and holds the CPU in reset until a full image is stored.
// Optional feature: define LOADER_CSUM_EN to require a trailing XOR checksum byte after the payload.
module imem_loader #(
  parameter int ADDR_W    = 10,
  parameter int BASE_WORD = 0
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              IN_VALID,
  input  logic [7:0]        IN_DATA,
  output logic              IN_READY,
  output logic              WE,
  output logic [ADDR_W-1:0] WADDR,
  output logic [31:0]       WDATA,
  output logic              CPU_RST_X,
  output logic              DONE,
  output logic              ERR
);

  localparam logic [ADDR_W-1:0] BASE_ADDR = ADDR_W'(BASE_WORD);
  localparam logic [31:0] MAX_WORDS = (ADDR_W >= 31) ? 32'hFFFF_FFFF : (32'd1 << ADDR_W);
  localparam logic [7:0] SYNC_BYTE = 8'hA5;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LEN0 = 3'd1,
    S_LEN1 = 3'd2,
    S_DATA = 3'd3,
    S_FIN  = 3'd4,
    S_ERR  = 3'd5
`ifdef LOADER_CSUM_EN
    , S_CSUM = 3'd6
`endif
  } state_t;

`ifdef LOADER_CSUM_EN
  localparam state_t END_STATE = S_CSUM;
`else
  localparam state_t END_STATE = S_FIN;
`endif

  state_t            state_r, state_n;
  logic [7:0]        len_lo_r, len_lo_n;
  logic [15:0]       left_r, left_n;
  logic [ADDR_W-1:0] addr_r, addr_n;
  logic [1:0]        bidx_r, bidx_n;
  logic [23:0]       shift_r, shift_n;
  logic              in_ready_r;
  logic              we_r, we_n;
  logic [ADDR_W-1:0] waddr_r, waddr_n;
  logic [31:0]       wdata_r, wdata_n;
  logic              cpu_rst_x_r, done_r, done_n, err_r, err_n;
  logic              fire_s;
  logic [15:0]       len_s;
`ifdef LOADER_CSUM_EN
  logic [7:0]        csum_r, csum_n;
`endif

  assign fire_s = IN_VALID & in_ready_r;
  assign len_s  = {IN_DATA, len_lo_r};

  // Next-state, word assembly and registered-output intent
  always_comb begin
    state_n  = state_r;
    len_lo_n = len_lo_r;
    left_n   = left_r;
    addr_n   = addr_r;
    bidx_n   = bidx_r;
    shift_n  = shift_r;
    we_n     = 1'b0;
    waddr_n  = waddr_r;
    wdata_n  = wdata_r;
`ifdef LOADER_CSUM_EN
    csum_n   = csum_r;
`endif
    case (state_r)
      S_IDLE, S_FIN: begin
        if (fire_s && (IN_DATA == SYNC_BYTE)) begin
          state_n = S_LEN0;
        end else begin
          state_n = state_r;
        end
      end
      S_LEN0: begin
        if (fire_s) begin
          len_lo_n = IN_DATA;
          state_n  = S_LEN1;
`ifdef LOADER_CSUM_EN
          csum_n   = IN_DATA;
`endif
        end else begin
          state_n = state_r;
        end
      end
      S_LEN1: begin
        if (fire_s) begin
`ifdef LOADER_CSUM_EN
          csum_n = csum_r ^ IN_DATA;
`endif
          if (len_s == 16'd0) begin
            state_n = END_STATE;
          end else if ({16'd0, len_s} > MAX_WORDS) begin
            state_n = S_ERR;
          end else begin
            state_n = S_DATA;
            left_n  = len_s;
            addr_n  = BASE_ADDR;
            bidx_n  = 2'd0;
          end
        end else begin
          state_n = state_r;
        end
      end
      S_DATA: begin
        if (fire_s) begin
`ifdef LOADER_CSUM_EN
          csum_n  = csum_r ^ IN_DATA;
`endif
          bidx_n  = bidx_r + 2'd1;
          shift_n = {IN_DATA, shift_r[23:8]};
          // Byte 0 ends up in the low lane once the fourth byte lands on top.
          if (bidx_r == 2'd3) begin
            we_n    = 1'b1;
            waddr_n = addr_r;
            wdata_n = {IN_DATA, shift_r};
            addr_n  = addr_r + ADDR_W'(1);
            left_n  = left_r - 16'd1;
            if (left_r == 16'd1) begin
              state_n = END_STATE;
            end else begin
              state_n = S_DATA;
            end
          end else begin
            state_n = S_DATA;
          end
        end else begin
          state_n = state_r;
        end
      end
`ifdef LOADER_CSUM_EN
      S_CSUM: begin
        if (fire_s) begin
          if (IN_DATA == csum_r) begin
            state_n = S_FIN;
          end else begin
            state_n = S_ERR;
          end
        end else begin
          state_n = state_r;
        end
      end
`endif
      S_ERR: begin
        state_n = S_ERR;
      end
      default: begin
        state_n = S_ERR;
      end
    endcase
    // The last word's write pulse goes out first; DONE follows one cycle later.
    done_n = (state_n == S_FIN) && !we_n;
    err_n  = (state_n == S_ERR);
  end

  // State and output registers with synchronous reset
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_r     <= S_IDLE;
      len_lo_r    <= 8'd0;
      left_r      <= 16'd0;
      addr_r      <= BASE_ADDR;
      bidx_r      <= 2'd0;
      shift_r     <= 24'd0;
      in_ready_r  <= 1'b0;
      we_r        <= 1'b0;
      waddr_r     <= BASE_ADDR;
      wdata_r     <= 32'd0;
      cpu_rst_x_r <= 1'b0;
      done_r      <= 1'b0;
      err_r       <= 1'b0;
`ifdef LOADER_CSUM_EN
      csum_r      <= 8'd0;
`endif
    end else begin
      state_r     <= state_n;
      len_lo_r    <= len_lo_n;
      left_r      <= left_n;
      addr_r      <= addr_n;
      bidx_r      <= bidx_n;
      shift_r     <= shift_n;
      in_ready_r  <= 1'b1;
      we_r        <= we_n;
      waddr_r     <= waddr_n;
      wdata_r     <= wdata_n;
      cpu_rst_x_r <= done_n;
      done_r      <= done_n;
      err_r       <= err_n;
`ifdef LOADER_CSUM_EN
      csum_r      <= csum_n;
`endif
    end
  end

  assign IN_READY  = in_ready_r;
  assign WE        = we_r;
  assign WADDR     = waddr_r;
  assign WDATA     = wdata_r;
  assign CPU_RST_X = cpu_rst_x_r;
  assign DONE      = done_r;
  assign ERR       = err_r;

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: randomized frame stimulus checked against a write-list model of the loader.
// Honours LOADER_CSUM_EN by appending checksum bytes when it is defined.
module tb_imem_loader;

  localparam int TB_AW   = 4;
  localparam int TB_BASE = 13;
  localparam int TB_MAX  = 1 << TB_AW;

  typedef struct {
    logic [TB_AW-1:0] addr;
    logic [31:0]      data;
  } wr_t;

  logic             CLK = 1'b0;
  logic             RST = 1'b1;
  logic             IN_VALID = 1'b0;
  logic [7:0]       IN_DATA = 8'd0;
  logic             IN_READY, WE, CPU_RST_X, DONE, ERR;
  logic [TB_AW-1:0] WADDR;
  logic [31:0]      WDATA;

  int          n_checks = 0;
  int          n_pass   = 0;
  int          gap_fixed = -1;
  bit          loaded = 1'b0;
  wr_t         exp_q[$];
  logic [31:0] payload_q[$];

  imem_loader #(.ADDR_W(TB_AW), .BASE_WORD(TB_BASE)) dut (
    .CLK(CLK), .RST(RST), .IN_VALID(IN_VALID), .IN_DATA(IN_DATA), .IN_READY(IN_READY),
    .WE(WE), .WADDR(WADDR), .WDATA(WDATA), .CPU_RST_X(CPU_RST_X), .DONE(DONE), .ERR(ERR)
  );

  always #5 CLK = ~CLK;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, obs, exp, $time);
  endtask

  // Every write pulse must match the next entry of the expected write list
  always @(posedge CLK) begin : monitor
    wr_t e;
    #1;
    if (WE === 1'b1) begin
      if (exp_q.size() == 0) begin
        check_eq("we_unexpected", {31'd0, WE}, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check_eq("waddr", {{(32-TB_AW){1'b0}}, WADDR}, {{(32-TB_AW){1'b0}}, e.addr});
        check_eq("wdata", WDATA, e.data);
      end
    end
  end

  function automatic int rg(input int m);
    if (gap_fixed >= 0) return gap_fixed;
    return (m == 0) ? 0 : int'($urandom_range(m, 0));
  endfunction

  task automatic send_byte(input logic [7:0] b, input int gap);
    logic rdy;
    rdy = 1'b0;
    IN_VALID = 1'b0;
    repeat (gap) begin @(posedge CLK); #2; end
    IN_VALID = 1'b1;
    IN_DATA  = b;
    for (int i = 0; i < 20; i++) begin
      @(negedge CLK);
      rdy = IN_READY;
      @(posedge CLK);
      #2;
      if (rdy) break;
    end
    if (!rdy) check_eq("ready_timeout", {31'd0, rdy}, 32'd1);
    IN_VALID = 1'b0;
  endtask

  task automatic do_reset();
    IN_VALID = 1'b0;
    RST = 1'b1;
    @(posedge CLK); #2;
    exp_q.delete();
    loaded = 1'b0;
    check_eq("rst_ready", {31'd0, IN_READY}, 32'd0);
    check_eq("rst_we", {31'd0, WE}, 32'd0);
    check_eq("rst_waddr", {{(32-TB_AW){1'b0}}, WADDR}, 32'(TB_BASE));
    check_eq("rst_wdata", WDATA, 32'd0);
    check_eq("rst_cpu", {31'd0, CPU_RST_X}, 32'd0);
    check_eq("rst_done", {31'd0, DONE}, 32'd0);
    check_eq("rst_err", {31'd0, ERR}, 32'd0);
    RST = 1'b0;
    @(posedge CLK); #2;
    check_eq("ready_after_rst", {31'd0, IN_READY}, 32'd1);
  endtask

  // Send one frame built from payload_q; the model is the list of expected writes plus the final flags
  task automatic send_frame(input int gap_max, input bit bad_csum);
    int          n;
    bit          csum_sent;
    logic [7:0]  cs, b;
    logic [31:0] w;
    n = payload_q.size();
    csum_sent = 1'b0;
    cs = 8'(n) ^ 8'(n >> 8);
    send_byte(8'hA5, rg(gap_max));
    if (loaded) begin
      check_eq("reload_done", {31'd0, DONE}, 32'd0);
      check_eq("reload_cpu", {31'd0, CPU_RST_X}, 32'd0);
    end
    send_byte(8'(n), rg(gap_max));
    send_byte(8'(n >> 8), rg(gap_max));
    for (int k = 0; k < n; k++) begin
      w = payload_q[k];
      exp_q.push_back('{addr: TB_AW'((TB_BASE + k) % TB_MAX), data: w});
      for (int j = 0; j < 4; j++) begin
        b = w[8*j +: 8];
        cs = cs ^ b;
        send_byte(b, rg(gap_max));
      end
    end
`ifdef LOADER_CSUM_EN
    send_byte(cs ^ {7'd0, bad_csum}, rg(gap_max));
    csum_sent = 1'b1;
`endif
    if (csum_sent && bad_csum) begin
      check_eq("csum_err", {31'd0, ERR}, 32'd1);
      check_eq("csum_err_cpu", {31'd0, CPU_RST_X}, 32'd0);
      check_eq("csum_err_done", {31'd0, DONE}, 32'd0);
      loaded = 1'b0;
    end else begin
      if (!csum_sent && n > 0) begin
        check_eq("done_early", {31'd0, DONE}, 32'd0);
        check_eq("cpu_early", {31'd0, CPU_RST_X}, 32'd0);
        @(posedge CLK); #2;
      end
      check_eq("done", {31'd0, DONE}, 32'd1);
      check_eq("cpu_run", {31'd0, CPU_RST_X}, 32'd1);
      check_eq("no_err", {31'd0, ERR}, 32'd0);
      loaded = 1'b1;
    end
    @(posedge CLK); #2;
    check_eq("writes_left", 32'(exp_q.size()), 32'd0);
    if (n > 0) check_eq("wdata_hold", WDATA, payload_q[n-1]);
  endtask

  task automatic send_junk(input int cnt);
    logic [7:0] b;
    for (int i = 0; i < cnt; i++) begin
      b = 8'($urandom);
      if (b == 8'hA5) b = 8'h5A;
      send_byte(b, rg(1));
    end
  endtask

  initial begin
    int n;
    do_reset();

    // Basic three-word image, one byte per cycle
    payload_q = '{32'h0000_0000, 32'h00A0_0293, 32'h0200_0313};
    send_frame(0, 1'b0);

    // Reload from the loaded state
    payload_q = '{32'h0000_00EF};
    send_frame(0, 1'b0);

    // Junk then a gapped single-word frame
    do_reset();
    send_byte(8'h00, 0); send_byte(8'hFF, 0); send_byte(8'h5A, 0);
    gap_fixed = 3;
    payload_q = '{32'h0C40_006F};
    send_frame(0, 1'b0);
    gap_fixed = -1;

    // Zero-length image
    payload_q.delete();
    send_frame(0, 1'b0);

    // Largest legal image wraps the write address past the top of IMEM
    payload_q.delete();
    for (int k = 0; k < TB_MAX; k++) payload_q.push_back($urandom);
    send_frame(1, 1'b0);

    // Random frames, gaps and junk
    for (int f = 0; f < 8; f++) begin
      n = int'($urandom_range(TB_MAX, 0));
      payload_q.delete();
      for (int k = 0; k < n; k++) payload_q.push_back($urandom);
      send_junk(int'($urandom_range(2, 0)));
      send_frame(int'($urandom_range(2, 0)), 1'b0);
    end

    // Oversize length: error is sticky through further traffic
    do_reset();
    send_byte(8'hA5, 0); send_byte(8'h11, 0); send_byte(8'h00, 0);
    check_eq("oversize_err", {31'd0, ERR}, 32'd1);
    check_eq("oversize_cpu", {31'd0, CPU_RST_X}, 32'd0);
    for (int i = 0; i < 20; i++) send_byte((i % 5 == 0) ? 8'hA5 : 8'($urandom), 0);
    check_eq("err_sticky", {31'd0, ERR}, 32'd1);
    check_eq("err_done", {31'd0, DONE}, 32'd0);
    check_eq("err_cpu", {31'd0, CPU_RST_X}, 32'd0);

    do_reset();
    n = int'($urandom_range(65535, TB_MAX + 1));
    send_byte(8'hA5, 0); send_byte(8'(n), 1); send_byte(8'(n >> 8), 0);
    check_eq("oversize_rand_err", {31'd0, ERR}, 32'd1);

    // Reset in the middle of a word discards it
    do_reset();
    send_byte(8'hA5, 0); send_byte(8'h02, 0); send_byte(8'h00, 0);
    send_byte(8'h93, 0); send_byte(8'h02, 0);
    do_reset();
    payload_q = '{$urandom};
    send_frame(0, 1'b0);

`ifdef LOADER_CSUM_EN
    // Corrupted checksum: words are still written but the CPU stays in reset
    do_reset();
    payload_q = '{32'h00A0_0293};
    send_frame(0, 1'b1);
    repeat (3) @(posedge CLK);
    #2;
    check_eq("csum_err_sticky", {31'd0, ERR}, 32'd1);
`endif

    repeat (3) @(posedge CLK);
    #2;
    check_eq("final_writes_left", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: time limit reached, got no finish expected finish");
    $fatal(1, "watchdog");
  end

endmodule
